// File: rtl/tile_step_controller.sv
// tile_step_controller: frame-locked tile-step sequencer with a collision query handshake.
// Turns held direction keycodes into whole-tile moves that are animated over several frames.
module tile_step_controller #(
    parameter int TILE   = 16,
    parameter int STEP   = 2,
    parameter int X_MAX  = 624,
    parameter int Y_MAX  = 464,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_vs,
    input  logic [7:0] keycode,
    output logic       query_valid,
    output logic [5:0] query_tx,
    output logic [4:0] query_ty,
    input  logic       query_ack,
    input  logic       query_blocked,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [1:0] facing,
    output logic       moving,
    output logic [1:0] walk_phase
);
    localparam int TB = $clog2(TILE);
    localparam int RW = TB + 1;
    localparam logic signed [10:0] T11 = 11'(TILE);
    localparam logic signed [10:0] X11 = 11'(X_MAX);
    localparam logic signed [10:0] Y11 = 11'(Y_MAX);
    localparam logic [RW-1:0] TILE_R = RW'(TILE);
    localparam logic [RW-1:0] STEP_R = RW'(STEP);
    localparam logic [9:0] STEP_P = 10'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_QUERY, S_STEP} state_t;

    state_t state, state_n;
    logic vs_s1, vs_s2, vs_d, tick;
    logic [9:0] pos_x_n, pos_y_n;
    logic [1:0] facing_n, walk_n, key_face;
    logic [5:0] query_tx_n;
    logic [4:0] query_ty_n;
    logic [RW-1:0] rem, rem_n;
    logic is_dir, in_bounds;
    logic signed [10:0] px, py, cx, cy;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            {vs_s1, vs_s2, vs_d} <= 3'b111;
            tick <= 1'b0;
        end else begin
            vs_s1 <= frame_vs;
            vs_s2 <= vs_s1;
            vs_d <= vs_s2;
            tick <= vs_s2 & ~vs_d;
        end
    end

    assign is_dir = keycode == 8'h1A || keycode == 8'h16 || keycode == 8'h04 || keycode == 8'h07;
    assign key_face = keycode == 8'h1A ? 2'd1 : keycode == 8'h04 ? 2'd2 : keycode == 8'h07 ? 2'd3 : 2'd0;
    assign px = signed'({1'b0, PosX});
    assign py = signed'({1'b0, PosY});
    // Signed 11-bit targets keep a step off the left/top edge negative instead of wrapping.
    assign cx = key_face == 2'd3 ? px + T11 : key_face == 2'd2 ? px - T11 : px;
    assign cy = key_face == 2'd0 ? py + T11 : key_face == 2'd1 ? py - T11 : py;
    assign in_bounds = cx >= 11'sd0 && cx <= X11 && cy >= 11'sd0 && cy <= Y11;
    assign query_valid = state == S_QUERY;
    assign moving = state == S_STEP;

    always_comb begin
        state_n = state;
        pos_x_n = PosX;
        pos_y_n = PosY;
        facing_n = facing;
        walk_n = walk_phase;
        query_tx_n = query_tx;
        query_ty_n = query_ty;
        rem_n = rem;
        case (state)
            S_IDLE: if (tick && is_dir) begin
                facing_n = key_face;
                if (in_bounds) begin
                    query_tx_n = cx[TB +: 6];
                    query_ty_n = cy[TB +: 5];
                    state_n = S_QUERY;
                end
            end
            S_QUERY: if (query_ack) begin
                state_n = query_blocked ? S_IDLE : S_STEP;
                rem_n = TILE_R;
            end
            S_STEP: if (tick) begin
                pos_x_n = facing == 2'd3 ? PosX + STEP_P : facing == 2'd2 ? PosX - STEP_P : PosX;
                pos_y_n = facing == 2'd0 ? PosY + STEP_P : facing == 2'd1 ? PosY - STEP_P : PosY;
                rem_n = rem - STEP_R;
                if (rem == STEP_R) begin
                    state_n = S_IDLE;
                    walk_n = walk_phase + 2'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            PosX <= 10'(X_INIT);
            PosY <= 10'(Y_INIT);
            facing <= 2'd0;
            walk_phase <= 2'd0;
            query_tx <= 6'd0;
            query_ty <= 5'd0;
            rem <= '0;
        end else begin
            state <= state_n;
            PosX <= pos_x_n;
            PosY <= pos_y_n;
            facing <= facing_n;
            walk_phase <= walk_n;
            query_tx <= query_tx_n;
            query_ty <= query_ty_n;
            rem <= rem_n;
        end
    end
endmodule

// File: tb/tb_tile_step_controller.sv
// tb_tile_step_controller: directed checks of stepping, blocking, edges, reset and chaining.
module tb_tile_step_controller;
    logic Clk, Reset, frame_vs, query_ack, query_blocked;
    logic [7:0] keycode;
    logic query_valid, moving;
    logic [5:0] query_tx;
    logic [4:0] query_ty;
    logic [9:0] PosX, PosY;
    logic [1:0] facing, walk_phase;
    int checks = 0;
    int errors = 0;

    tile_step_controller dut (
        .Clk(Clk), .Reset(Reset), .frame_vs(frame_vs), .keycode(keycode),
        .query_valid(query_valid), .query_tx(query_tx), .query_ty(query_ty),
        .query_ack(query_ack), .query_blocked(query_blocked),
        .PosX(PosX), .PosY(PosY), .facing(facing), .moving(moving), .walk_phase(walk_phase)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Tick reaches the FSM on the 4th edge after the rise; return at the following negedge.
    task automatic tick();
        frame_vs = 1'b0;
        repeat (3) @(negedge Clk);
        frame_vs = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    task automatic ack(input logic blk, input int dly);
        repeat (dly) @(negedge Clk);
        query_ack = 1'b1;
        query_blocked = blk;
        @(negedge Clk);
        query_ack = 1'b0;
        query_blocked = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        keycode = 8'h00;
        frame_vs = 1'b1;
        query_ack = 1'b0;
        query_blocked = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic step(input logic [7:0] k, input int dly);
        keycode = k;
        tick();
        for (int i = 0; i < 20 && !query_valid; i++) @(negedge Clk);
        chk("step_qv", query_valid, 1);
        ack(1'b0, dly);
        repeat (8) tick();
    endtask

    initial begin
        Reset = 1'b0;
        keycode = 8'h00;
        frame_vs = 1'b1;
        query_ack = 1'b0;
        query_blocked = 1'b0;
        #12;
        chk("rst_x", PosX, 320);
        chk("rst_y", PosY, 240);
        chk("rst_face", facing, 0);
        chk("rst_mov", moving, 0);
        chk("rst_walk", walk_phase, 0);
        chk("rst_qv", query_valid, 0);
        chk("rst_tx", query_tx, 0);
        chk("rst_ty", query_ty, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        keycode = 8'h07;
        tick();
        chk("r_face", facing, 3);
        chk("r_qv", query_valid, 1);
        chk("r_tx", query_tx, 21);
        chk("r_ty", query_ty, 15);
        chk("r_mov0", moving, 0);
        ack(1'b0, 0);
        chk("r_qv_drop", query_valid, 0);
        chk("r_mov1", moving, 1);
        keycode = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("r_posx", PosX, 322 + 2 * i);
            chk("r_mov", moving, i < 7 ? 1 : 0);
        end
        chk("r_walk", walk_phase, 1);
        chk("r_posy", PosY, 240);

        do_reset();
        keycode = 8'h1A;
        tick();
        chk("b_face", facing, 1);
        chk("b_qv", query_valid, 1);
        chk("b_ty", query_ty, 14);
        ack(1'b1, 2);
        chk("b_qv_drop", query_valid, 0);
        chk("b_mov", moving, 0);
        keycode = 8'h00;
        tick();
        chk("b_posy", PosY, 240);
        chk("b_mov2", moving, 0);
        chk("b_qv2", query_valid, 0);

        do_reset();
        for (int i = 0; i < 20; i++) step(8'h04, 1);
        chk("l_posx", PosX, 0);
        chk("l_walk", walk_phase, 0);
        keycode = 8'h07;
        tick();
        chk("l_face3", facing, 3);
        ack(1'b1, 0);
        keycode = 8'h04;
        tick();
        chk("l_edge_qv", query_valid, 0);
        chk("l_edge_face", facing, 2);
        chk("l_edge_x", PosX, 0);
        for (int i = 0; i < 14; i++) step(8'h16, 0);
        chk("d_posy", PosY, 464);
        chk("d_walk", walk_phase, 2);
        keycode = 8'h1A;
        tick();
        ack(1'b1, 0);
        keycode = 8'h16;
        tick();
        chk("d_edge_qv", query_valid, 0);
        chk("d_edge_face", facing, 0);
        chk("d_edge_y", PosY, 464);

        do_reset();
        keycode = 8'h07;
        tick();
        ack(1'b0, 0);
        repeat (3) tick();
        keycode = 8'h04;
        repeat (5) tick();
        chk("k_posx", PosX, 336);
        chk("k_mov", moving, 0);
        chk("k_face", facing, 3);
        tick();
        chk("k_face2", facing, 2);
        chk("k_qv", query_valid, 1);
        chk("k_tx", query_tx, 20);

        do_reset();
        keycode = 8'h07;
        tick();
        ack(1'b0, 0);
        repeat (4) tick();
        chk("m_posx", PosX, 328);
        #2 Reset = 1'b0;
        #1;
        chk("m_rst_x", PosX, 320);
        chk("m_rst_mov", moving, 0);
        chk("m_rst_qv", query_valid, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        tick();
        chk("q_qv", query_valid, 1);
        #2 Reset = 1'b0;
        #1;
        chk("q_rst_qv", query_valid, 0);
        chk("q_rst_tx", query_tx, 0);
        chk("q_rst_face", facing, 0);
        keycode = 8'h00;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        ack(1'b0, 0);
        repeat (2) tick();
        chk("q_late_x", PosX, 320);
        chk("q_late_mov", moving, 0);
        chk("q_late_qv", query_valid, 0);

        do_reset();
        keycode = 8'h16;
        tick();
        chk("c_qv", query_valid, 1);
        chk("c_ty", query_ty, 16);
        tick();
        chk("c_qv_hold", query_valid, 1);
        chk("c_ty_hold", query_ty, 16);
        chk("c_y_hold", PosY, 240);
        ack(1'b0, 5);
        repeat (8) tick();
        chk("c_y1", PosY, 256);
        step(8'h16, 5);
        step(8'h16, 5);
        chk("c_y3", PosY, 288);
        chk("c_walk3", walk_phase, 3);
        step(8'h16, 5);
        chk("c_y4", PosY, 304);
        chk("c_walk4", walk_phase, 0);
        chk("c_mov", moving, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
